rx_frame_analyser: RTL

//   Receive-path frame analyser for the UART Rx core; parametrised successor of the fixed 8-bit byte analyser.

---
 rtl/rx_frame_analyser.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_analyser.sv
// Rx frame analyser: captures frame data, checks parity and stop bit, and
// writes good frames to the Rx FIFO with a one-cycle active-low strobe.
module rx_frame_analyser #(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned SHIFT_W    = 12,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned ACQ_POINT  = 7,
  parameter int unsigned CNT_W_STAT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            state_i,
  input  logic [CNT_W-1:0]      bit_cnt_i,
  input  logic [SHIFT_W-1:0]    shift_i,
  input  logic [3:0]            data_len_i,
  input  logic [2:0]            parity_mode_i,
  input  logic                  big_end_i,
  input  logic                  err_clr_i,
  output logic                  n_we_o,
  output logic [DATA_W-1:0]     data_o,
  input  logic                  p_full_i,
  output logic                  p_parity_err_o,
  output logic                  p_frame_err_o,
  output logic                  p_overrun_err_o,
  output logic [CNT_W_STAT-1:0] frame_cnt_o,
  output logic [CNT_W_STAT-1:0] drop_cnt_o
);

  localparam int unsigned JUDGE_POINT = ACQ_POINT + 1;
  localparam int unsigned DATA_POINT  = ACQ_POINT + 2;
  localparam int unsigned FIFO_POINT  = ACQ_POINT + 3;

  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_START  = 5'b00010;
  localparam logic [4:0] ST_DATA   = 5'b00100;
  localparam logic [4:0] ST_PARITY = 5'b01000;
  localparam logic [4:0] ST_STOP   = 5'b10000;

  logic                  r_n_we;
  logic [DATA_W-1:0]     r_data;
  logic                  r_parity_bad;
  logic                  r_frame_bad;
  logic                  r_trig_d;
  logic                  r_parity_err;
  logic                  r_frame_err;
  logic                  r_overrun_err;
  logic [CNT_W_STAT-1:0] r_frame_cnt;
  logic [CNT_W_STAT-1:0] r_drop_cnt;

  logic [3:0]        w_len;
  logic [DATA_W-1:0] w_cap;
  logic              w_xor;
  logic              w_par_err;
  logic              w_frame_start;
  logic              w_capture;
  logic              w_par_judge;
  logic              w_stop_judge;
  logic              w_trig;
  logic              w_edge;
  logic              w_good;
  logic              w_write;
  logic              w_drop;
  logic              w_set_par;
  logic              w_set_frm;
  logic              w_set_ovr;

  // Shift register bits above the data+parity window carry nothing we use.
  if (SHIFT_W > DATA_W + 1) begin : g_unused
    logic w_unused_shift;
    assign w_unused_shift = ^shift_i[SHIFT_W-1:DATA_W+1];
  end

  // Effective data length; out-of-range requests fall back to DATA_W.
  always_comb begin
    w_len = 4'(DATA_W);
    if (data_len_i >= 4'd5 && 32'(data_len_i) <= DATA_W) begin
      w_len = data_len_i;
    end
  end

  // Reorder the shift register into data bits according to bit order.
  always_comb begin
    w_cap = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (i < int'(w_len)) begin
        w_cap[i] = big_end_i ? shift_i[i] : shift_i[int'(w_len) - 1 - i];
      end
    end
  end

  // XOR over data bits plus the parity bit sitting at shift_i[0].
  always_comb begin
    w_xor = 1'b0;
    for (int i = 0; i <= int'(DATA_W); i++) begin
      if (i <= int'(w_len)) begin
        w_xor = w_xor ^ shift_i[i];
      end
    end
  end

  // Parity verdict for the selected mode.
  always_comb begin
    w_par_err = 1'b0;
    case (parity_mode_i)
      3'd1:    w_par_err = w_xor;
      3'd2:    w_par_err = ~w_xor;
      3'd3:    w_par_err = ~shift_i[0];
      3'd4:    w_par_err = shift_i[0];
      default: w_par_err = 1'b0;
    endcase
  end

  assign w_frame_start = (state_i == ST_IDLE) || (state_i == ST_START);
  assign w_capture     = (state_i == ST_DATA)   && (bit_cnt_i == CNT_W'(DATA_POINT));
  assign w_par_judge   = (state_i == ST_PARITY) && (bit_cnt_i == CNT_W'(JUDGE_POINT));
  assign w_stop_judge  = (state_i == ST_STOP)   && (bit_cnt_i == CNT_W'(JUDGE_POINT));
  assign w_trig        = (state_i == ST_STOP)   && (bit_cnt_i == CNT_W'(FIFO_POINT));
  assign w_edge        = w_trig & ~r_trig_d;
  assign w_good        = ~r_parity_bad & ~r_frame_bad;
  assign w_write       = w_edge & w_good & ~p_full_i;
  assign w_drop        = w_edge & ~w_write;
  assign w_set_par     = w_edge & r_parity_bad;
  assign w_set_frm     = w_edge & r_frame_bad;
  assign w_set_ovr     = w_edge & w_good & p_full_i;

  // Frame data register: cleared between frames, last capture wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (w_frame_start) begin
      r_data <= '0;
    end else if (w_capture) begin
      r_data <= w_cap;
    end
  end

  // Per-frame error flags, reset at the start of every frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity_bad <= 1'b0;
      r_frame_bad  <= 1'b0;
    end else if (w_frame_start || state_i == ST_DATA) begin
      r_parity_bad <= 1'b0;
      r_frame_bad  <= 1'b0;
    end else begin
      if (w_par_judge && w_par_err) r_parity_bad <= 1'b1;
      if (w_stop_judge && !shift_i[0]) r_frame_bad <= 1'b1;
    end
  end

  // Write strobe on the rising edge of the trigger condition only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trig_d <= 1'b0;
      r_n_we   <= 1'b1;
    end else begin
      r_trig_d <= w_trig;
      r_n_we   <= ~w_write;
    end
  end

  // Sticky error flags; a set wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_parity_err  <= (r_parity_err  & ~err_clr_i) | w_set_par;
      r_frame_err   <= (r_frame_err   & ~err_clr_i) | w_set_frm;
      r_overrun_err <= (r_overrun_err & ~err_clr_i) | w_set_ovr;
    end
  end

  // Written and dropped frame counters, wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_write) r_frame_cnt <= r_frame_cnt + CNT_W_STAT'(1);
      if (w_drop)  r_drop_cnt  <= r_drop_cnt + CNT_W_STAT'(1);
    end
  end

  assign n_we_o          = r_n_we;
  assign data_o          = r_data;
  assign p_parity_err_o  = r_parity_err;
  assign p_frame_err_o   = r_frame_err;
  assign p_overrun_err_o = r_overrun_err;
  assign frame_cnt_o     = r_frame_cnt;
  assign drop_cnt_o      = r_drop_cnt;

endmodule
